// File: rtl/ms_wb_bus_mux_pkg.sv
// Shared definitions for the Wishbone 1-to-3 bus multiplexer.
// Holds slave slot address codes (adr[19:16]), FSM state encoding,
// bus-error cause codes and the address decode helper.
package ms_wb_bus_mux_pkg;

    localparam int unsigned NumSlots = 3;

    // adr[19:16] codes selecting each slave slot
    localparam logic [3:0] SlotCode0 = 4'h0;
    localparam logic [3:0] SlotCode1 = 4'h2;
    localparam logic [3:0] SlotCode2 = 4'h4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StErr   = 2'd2,
        StRecov = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CauseNone     = 2'b00,
        CauseUnmapped = 2'b01,
        CauseTimeout  = 2'b10
    } err_cause_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } slot_dec_t;

    function automatic slot_dec_t decode_slot(input logic [3:0] code);
        slot_dec_t d;
        d.hit = 1'b1;
        d.idx = 2'd0;
        case (code)
            SlotCode0: d.idx = 2'd0;
            SlotCode1: d.idx = 2'd1;
            SlotCode2: d.idx = 2'd2;
            default:   d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ms_wb_timeout_ctr.sv
// 8-bit slave-response timeout counter.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : load zero (takes priority over inc_i)
//   inc_i          : increment by one
//   last_o         : counter currently holds Limit-1, i.e. this is the final
//                    cycle the slave is allowed before a timeout
module ms_wb_timeout_ctr #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam logic [7:0] LastVal = 8'(Limit - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LastVal);

endmodule

// File: rtl/ms_wb_bus_mux.sv
// Wishbone classic 1-master to 3-slave bus multiplexer with timeout and
// unmapped-address bus-error reporting.
// Ports:
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   wbs_*_i / wbs_ack_o, wbs_dat_o : master side (read data is 0 unless acking)
//   slv_stb_o[2:0]            : per-slot strobe, driven from state flops only
//   slv_ack_i[2:0], slv_dat_i : per-slot ack and read data (slot n at 32n+:32)
//   err_o, err_adr_o, err_cause_o : sticky first-error record
//   err_clr_i                 : single-cycle clear of the error record
module ms_wb_bus_mux
    import ms_wb_bus_mux_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  slv_stb_o,
    input  logic [2:0]  slv_ack_i,
    input  logic [95:0] slv_dat_i,
    output logic        err_o,
    output logic [31:0] err_adr_o,
    output logic [1:0]  err_cause_o,
    input  logic        err_clr_i
);

    state_e      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [31:0] adr_q, adr_d;
    logic        err_q, err_d;
    logic [31:0] err_adr_q, err_adr_d;
    err_cause_e  cause_q, cause_d;

    logic        ctr_clr, ctr_inc, ctr_last;
    logic        err_set;
    logic [31:0] err_set_adr;
    err_cause_e  err_set_cause;
    logic        sel_ack;
    logic [31:0] sel_dat;
    slot_dec_t   dec;

    // Writes need no data path here; slaves see wbs_dat_i directly.
    logic unused_inputs;
    assign unused_inputs = ^{wbs_we_i, wbs_sel_i, wbs_dat_i};

    assign dec = decode_slot(wbs_adr_i[19:16]);

    ms_wb_timeout_ctr #(
        .Limit (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (ctr_clr),
        .inc_i   (ctr_inc),
        .last_o  (ctr_last)
    );

    // Only the latched slot's ack/data are visible; other slots are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = 32'h0;
        case (slot_q)
            2'd0:    begin sel_ack = slv_ack_i[0]; sel_dat = slv_dat_i[31:0];  end
            2'd1:    begin sel_ack = slv_ack_i[1]; sel_dat = slv_dat_i[63:32]; end
            2'd2:    begin sel_ack = slv_ack_i[2]; sel_dat = slv_dat_i[95:64]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        adr_d         = adr_q;
        ctr_clr       = 1'b0;
        ctr_inc       = 1'b0;
        err_set       = 1'b0;
        err_set_adr   = adr_q;
        err_set_cause = CauseNone;
        wbs_ack_o     = 1'b0;
        wbs_dat_o     = 32'h0;
        slv_stb_o     = 3'b000;
        unique case (state_q)
            StIdle: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d = wbs_adr_i;
                    if (dec.hit) begin
                        slot_d  = dec.idx;
                        ctr_clr = 1'b1;
                        state_d = StWait;
                    end else begin
                        err_set       = 1'b1;
                        err_set_adr   = wbs_adr_i;
                        err_set_cause = CauseUnmapped;
                        state_d       = StErr;
                    end
                end
            end
            StWait: begin
                slv_stb_o = 3'b001 << slot_q;
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: silent abort.
                    state_d = StIdle;
                end else if (sel_ack) begin
                    // Ack beats a timeout falling in the same cycle.
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = sel_dat;
                    state_d   = StRecov;
                end else if (ctr_last) begin
                    err_set       = 1'b1;
                    err_set_cause = CauseTimeout;
                    state_d       = StErr;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            StErr: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = ERR_DATA;
                state_d   = StRecov;
            end
            StRecov: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // First error is kept; a clear coinciding with a new error records the new one.
    always_comb begin
        err_d     = err_q;
        err_adr_d = err_adr_q;
        cause_d   = cause_q;
        if (err_set && (!err_q || err_clr_i)) begin
            err_d     = 1'b1;
            err_adr_d = err_set_adr;
            cause_d   = err_set_cause;
        end else if (err_clr_i) begin
            err_d     = 1'b0;
            err_adr_d = 32'h0;
            cause_d   = CauseNone;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            slot_q    <= 2'd0;
            adr_q     <= 32'h0;
            err_q     <= 1'b0;
            err_adr_q <= 32'h0;
            cause_q   <= CauseNone;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            adr_q     <= adr_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
            cause_q   <= cause_d;
        end
    end

    assign err_o       = err_q;
    assign err_adr_o   = err_adr_q;
    assign err_cause_o = cause_q;

endmodule

// File: tb/tb_ms_wb_bus_mux.sv
// Scoreboard bench for ms_wb_bus_mux (TIMEOUT = 4).
// Stimulus pushes the expected read data of each acked access; a monitor on
// the falling edge pops and compares on every wbs_ack_o cycle and checks that
// wbs_dat_o is zero otherwise.
module tb_ms_wb_bus_mux;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  slv_stb_o;
    logic [2:0]  slv_ack_i = 3'b000;
    logic [95:0] slv_dat_i = {32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_0000};
    logic        err_o;
    logic [31:0] err_adr_o;
    logic [1:0]  err_cause_o;
    logic        err_clr_i = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    ms_wb_bus_mux #(
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .slv_stb_o   (slv_stb_o),
        .slv_ack_i   (slv_ack_i),
        .slv_dat_i   (slv_dat_i),
        .err_o       (err_o),
        .err_adr_o   (err_adr_o),
        .err_cause_o (err_cause_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every ack must match the oldest expected read data.
    always @(negedge clk_i) begin
        n_cmp++;
        if (wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack: got ack with dat %h, required no ack", wbs_dat_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wbs_dat_o !== mon_exp) begin
                    n_bad++;
                    $display("FAIL ack_data: got %h required %h", wbs_dat_o, mon_exp);
                end
            end
        end else if (wbs_dat_o !== 32'h0) begin
            n_bad++;
            $display("FAIL idle_data: got %h required 00000000", wbs_dat_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic req(input logic [31:0] adr);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = adr;
    endtask

    task automatic idle_bus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stb"}, 32'(slv_stb_o), 32'h0);
        chk({tag, " ack"}, 32'(wbs_ack_o), 32'h0);
        chk({tag, " dat"}, wbs_dat_o, 32'h0);
        chk({tag, " err"}, 32'(err_o), 32'h0);
        chk({tag, " err_adr"}, err_adr_o, 32'h0);
        chk({tag, " cause"}, 32'(err_cause_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();

        // Slot 1 read, ack two cycles after strobe; stray slot-0 ack ignored
        req(32'h3002_0004);
        exp_q.push_back(32'h1234_5678);
        tick();
        slv_ack_i = 3'b001;
        chk("rd1 stb c1", 32'(slv_stb_o), 32'h2);
        tick();
        slv_ack_i = 3'b000;
        chk("rd1 stb c2", 32'(slv_stb_o), 32'h2);
        tick();
        slv_ack_i = 3'b010;
        tick();
        slv_ack_i = 3'b000;
        idle_bus();
        chk("rd1 stb recov", 32'(slv_stb_o), 32'h0);
        chk("rd1 err", 32'(err_o), 32'h0);
        tick();

        // Unmapped address
        req(32'h3006_0000);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("unmap err", 32'(err_o), 32'h1);
        chk("unmap err_adr", err_adr_o, 32'h3006_0000);
        chk("unmap cause", 32'(err_cause_o), 32'h1);
        chk("unmap stb", 32'(slv_stb_o), 32'h0);
        tick();
        idle_bus();
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr1 err", 32'(err_o), 32'h0);
        chk("clr1 cause", 32'(err_cause_o), 32'h0);

        // Slot 0 never acks: four strobe cycles then timeout error
        req(32'h3000_0010);
        exp_q.push_back(32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo stb", 32'(slv_stb_o), 32'h1);
        end
        tick();
        chk("tmo stb dropped", 32'(slv_stb_o), 32'h0);
        chk("tmo err", 32'(err_o), 32'h1);
        chk("tmo err_adr", err_adr_o, 32'h3000_0010);
        chk("tmo cause", 32'(err_cause_o), 32'h2);
        tick();
        idle_bus();
        tick();

        // Second error while flag set keeps the first record, then clear
        req(32'h300F_0000);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("err2 err_adr kept", err_adr_o, 32'h3000_0010);
        chk("err2 cause kept", 32'(err_cause_o), 32'h2);
        tick();
        idle_bus();
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr2 err", 32'(err_o), 32'h0);
        chk("clr2 err_adr", err_adr_o, 32'h0);
        chk("clr2 cause", 32'(err_cause_o), 32'h0);

        // Slot 2 acks on the last allowed cycle: ack wins, no error
        req(32'h3004_0000);
        exp_q.push_back(32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("edge stb", 32'(slv_stb_o), 32'h4);
        end
        tick();
        slv_ack_i = 3'b100;
        chk("edge stb c4", 32'(slv_stb_o), 32'h4);
        tick();
        slv_ack_i = 3'b000;
        idle_bus();
        chk("edge err", 32'(err_o), 32'h0);
        chk("edge stb recov", 32'(slv_stb_o), 32'h0);
        tick();

        // Master drops cyc while waiting; late slot-2 ack must not reach master
        req(32'h3004_0008);
        tick();
        chk("abort stb c1", 32'(slv_stb_o), 32'h4);
        tick();
        idle_bus();
        slv_ack_i = 3'b100;
        tick();
        chk("abort stb after", 32'(slv_stb_o), 32'h0);
        tick();
        slv_ack_i = 3'b000;
        chk("abort stb idle", 32'(slv_stb_o), 32'h0);
        chk("abort err", 32'(err_o), 32'h0);

        // Clear coincident with a new error: new error recorded
        req(32'h3008_0000);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("pre err_adr", err_adr_o, 32'h3008_0000);
        tick();
        idle_bus();
        tick();
        req(32'h300A_0000);
        err_clr_i = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        err_clr_i = 1'b0;
        chk("coinc err", 32'(err_o), 32'h1);
        chk("coinc err_adr", err_adr_o, 32'h300A_0000);
        chk("coinc cause", 32'(err_cause_o), 32'h1);
        tick();
        idle_bus();
        tick();

        // Asynchronous reset in WAIT with slave ack pending
        req(32'h3002_0000);
        tick();
        chk("rst stb before", 32'(slv_stb_o), 32'h2);
        slv_ack_i = 3'b010;
        #1;
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("async rst");
        idle_bus();
        slv_ack_i = 3'b000;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        tick();
        tick();
        chk("post rst stb", 32'(slv_stb_o), 32'h0);

        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
